fft_sample_loader: RTL and testbench

FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

---
 rtl/fft_pkg.sv | 15 +
 rtl/loader_decim.sv | 47 ++++
 rtl/fft_sample_loader.sv | 135 +++++++++++++
 tb/tb_fft_sample_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Definitions shared between the sample loader and the FFT engine:
// loader FSM state encoding and default frame/sample geometry.
package fft_pkg;

  localparam int FFT_DEPTH_LOG2 = 8;
  localparam int FFT_SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    KICK      = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_e;

endpackage

// File: rtl/loader_decim.sv
// Pair averager: holds the first sample of each pair and, on the second,
// presents their signed mean (a+b)>>>1 evaluated one bit wider than a sample.
module loader_decim
  import fft_pkg::*;
#(
  parameter int SAMPLE_W = FFT_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_data,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_data
);

  logic                       phase_r;
  logic signed [SAMPLE_W-1:0] first_r;

  function automatic logic signed [SAMPLE_W-1:0] pair_avg(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    return SAMPLE_W'(sum >>> 1);
  endfunction

  // Pair phase and first-sample holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      first_r <= {SAMPLE_W{1'b0}};
    end else if (clear) begin
      phase_r <= 1'b0;
    end else if (in_valid) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        first_r <= in_data;
      end
    end
  end

  assign out_valid = in_valid & phase_r;
  assign out_data  = pair_avg(first_r, in_data);

endmodule

// File: rtl/fft_sample_loader.sv
// Captures one frame of 2^DEPTH_LOG2 samples into FFT memory, then pulses Start.
// Optional LOADER_DECIM_EN: write the average of each consecutive sample pair.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DEPTH_LOG2 = FFT_DEPTH_LOG2,
  parameter int SAMPLE_W   = FFT_SAMPLE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [SAMPLE_W-1:0]   sample_in,
  input  logic                         sample_valid,
  input  logic                         arm,
  input  logic                         ready,
  input  logic                         done,
  output logic                         wr_en,
  output logic        [DEPTH_LOG2-1:0] wr_addr,
  output logic signed [SAMPLE_W-1:0]   wr_data,
  output logic                         start,
  output logic                         busy,
  output logic        [7:0]            frame_count
);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = {DEPTH_LOG2{1'b1}};
  localparam logic [DEPTH_LOG2-1:0] ADDR_STEP = DEPTH_LOG2'(1'b1);

  loader_state_e               state_r, next_state_s;
  logic [DEPTH_LOG2-1:0]       addr_r, addr_s;
  logic                        accept_s, enter_fill_s, write_s;
  logic signed [SAMPLE_W-1:0]  write_data_s;
  logic                        wr_en_r, wr_en_s, start_r, start_s, busy_r, busy_s;
  logic [DEPTH_LOG2-1:0]       wr_addr_r, wr_addr_s;
  logic signed [SAMPLE_W-1:0]  wr_data_r, wr_data_s;
  logic [7:0]                  frame_count_r, frame_count_s;

  assign accept_s     = sample_valid && (state_r == FILL);
  assign enter_fill_s = (state_r == IDLE) && (next_state_s == FILL);

`ifdef LOADER_DECIM_EN
  loader_decim #(.SAMPLE_W(SAMPLE_W)) u_decim (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (enter_fill_s),
    .in_valid (accept_s),
    .in_data  (sample_in),
    .out_valid(write_s),
    .out_data (write_data_s)
  );
`else
  assign write_s      = accept_s;
  assign write_data_s = sample_in;
`endif

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      addr_r        <= {DEPTH_LOG2{1'b0}};
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {DEPTH_LOG2{1'b0}};
      wr_data_r     <= {SAMPLE_W{1'b0}};
      start_r       <= 1'b0;
      busy_r        <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      state_r       <= next_state_s;
      addr_r        <= addr_s;
      wr_en_r       <= wr_en_s;
      wr_addr_r     <= wr_addr_s;
      wr_data_r     <= wr_data_s;
      start_r       <= start_s;
      busy_r        <= busy_s;
      frame_count_r <= frame_count_s;
    end
  end

  // Next-state decode; the last write of the frame moves to KICK without wrapping
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arm && ready) next_state_s = FILL;
        else              next_state_s = IDLE;
      end
      FILL: begin
        if (write_s && (addr_r == LAST_ADDR)) next_state_s = KICK;
        else                                  next_state_s = FILL;
      end
      KICK:    next_state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (done) next_state_s = IDLE;
        else      next_state_s = WAIT_DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; Start is taken from KICK so it lands after the final write
  always_comb begin
    wr_en_s       = write_s;
    wr_addr_s     = wr_addr_r;
    wr_data_s     = wr_data_r;
    addr_s        = addr_r;
    frame_count_s = frame_count_r;
    start_s       = (state_r == KICK);
    busy_s        = (next_state_s != IDLE);
    if (enter_fill_s) begin
      addr_s = {DEPTH_LOG2{1'b0}};
    end else if (write_s && (addr_r != LAST_ADDR)) begin
      addr_s = addr_r + ADDR_STEP;
    end else begin
      addr_s = addr_r;
    end
    if (write_s) begin
      wr_addr_s = addr_r;
      wr_data_s = write_data_s;
    end else begin
      wr_addr_s = wr_addr_r;
      wr_data_s = wr_data_r;
    end
    if ((state_r == WAIT_DONE) && done) begin
      frame_count_s = frame_count_r + 8'd1;
    end else begin
      frame_count_s = frame_count_r;
    end
  end

  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign start       = start_r;
  assign busy        = busy_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader at DEPTH_LOG2=3; pair averaging is
// modelled when LOADER_DECIM_EN is defined.
module tb_fft_sample_loader;

  localparam int DL2 = 3;
  localparam int SW  = 16;
  localparam int N   = 8;
`ifdef LOADER_DECIM_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic signed [SW-1:0]  sample_in = 16'sd0;
  logic                  sample_valid = 1'b0;
  logic                  arm = 1'b0;
  logic                  ready = 1'b0;
  logic                  done = 1'b0;
  logic                  wr_en;
  logic [DL2-1:0]        wr_addr;
  logic signed [SW-1:0]  wr_data;
  logic                  start;
  logic                  busy;
  logic [7:0]            frame_count;

  typedef struct {
    logic [DL2-1:0]       addr;
    logic signed [SW-1:0] data;
    int                   cyc;
  } exp_t;

  exp_t                 exp_q[$];
  int                   vectors = 0;
  int                   miscompares = 0;
  int                   cyc = 0;
  int                   start_count = 0;
  int                   starts_exp = 0;
  int                   write_count = 0;
  logic [DL2-1:0]       exp_addr = 3'd0;
  logic [7:0]           fc_exp = 8'd0;
  logic                 pair_phase = 1'b0;
  logic signed [SW-1:0] pair_first = 16'sd0;

  fft_sample_loader #(.DEPTH_LOG2(DL2), .SAMPLE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .ready(ready), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every write must match the oldest expectation, in its expected cycle
  always @(negedge clk) begin
    exp_t e;
    if (start) start_count = start_count + 1;
    if (wr_en) begin
      write_count = write_count + 1;
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL extra_write: got addr=%0d data=%0d at cyc=%0d, want no write", wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc !== e.cyc || start !== 1'b0) begin
          miscompares = miscompares + 1;
          $display("FAIL write: got addr=%0d data=%0d cyc=%0d start=%b, want addr=%0d data=%0d cyc=%0d start=0",
                   wr_addr, wr_data, cyc, start, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic signed [SW-1:0] d);
    exp_t e;
    e.addr = exp_addr;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
    exp_addr = exp_addr + 3'd1;
  endtask

  task automatic send_sample(input logic signed [SW-1:0] v, input int gap);
    int s;
    sample_in    = v;
    sample_valid = 1'b1;
`ifdef LOADER_DECIM_EN
    if (!pair_phase) begin
      pair_first = v;
      pair_phase = 1'b1;
    end else begin
      s = (int'(pair_first) + int'(v)) >>> 1;
      push_exp(SW'(s));
      pair_phase = 1'b0;
    end
`else
    s = int'(v);
    push_exp(SW'(s));
`endif
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame();
    arm   = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    arm        = 1'b0;
    exp_addr   = 3'd0;
    pair_phase = 1'b0;
    vectors = vectors + 1;
    if (busy !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL busy_on_arm: got %b want 1", busy);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    starts_exp = starts_exp + 1;
    while (start_count < starts_exp && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vectors = vectors + 1;
    if (start_count !== starts_exp) begin
      miscompares = miscompares + 1;
      $display("FAIL start_pulse: got %0d starts want %0d", start_count, starts_exp);
    end
  endtask

  task automatic finish_frame();
    done = 1'b1;
    @(posedge clk); #1;
    done   = 1'b0;
    fc_exp = fc_exp + 8'd1;
    vectors = vectors + 1;
    if (frame_count !== fc_exp || busy !== 1'b0 || start_count !== starts_exp || exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL frame_end: got count=%0d busy=%b starts=%0d pending=%0d, want count=%0d busy=0 starts=%0d pending=0",
               frame_count, busy, start_count, exp_q.size(), fc_exp, starts_exp);
    end
  endtask

  task automatic run_frame(input int gap, input bit rnd);
    start_frame();
    for (int i = 0; i < N * SPW; i++)
      send_sample(rnd ? SW'($urandom_range(0, 65535)) : SW'(i + 1), gap);
    wait_start();
    finish_frame();
  endtask

  task automatic test_reset();
    vectors = vectors + 1;
    if ({wr_en, wr_addr, wr_data, start, busy, frame_count} !== 30'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_idle: got en=%b addr=%0d data=%0d start=%b busy=%b count=%0d, want all 0",
               wr_en, wr_addr, wr_data, start, busy, frame_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_frame();
    for (int i = 0; i < 2 * SPW; i++) send_sample(SW'(16'h5A5A + i), 0);
    #6;
    rst_n = 1'b0;
    #1;
    vectors = vectors + 1;
    if ({wr_en, wr_addr, wr_data, start, busy, frame_count} !== 30'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_busy: got en=%b addr=%0d data=%0d start=%b busy=%b count=%0d, want all 0",
               wr_en, wr_addr, wr_data, start, busy, frame_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    fc_exp = 8'd0;
    arm   = 1'b1;
    ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      vectors = vectors + 1;
      if (busy !== 1'b0) begin
        miscompares = miscompares + 1;
        $display("FAIL arm_not_ready: got busy=%b want 0", busy);
      end
    end
    arm = 1'b0;
  endtask

  task automatic test_fill_basic();
    run_frame(0, 1'b0);
  endtask

  task automatic test_gaps();
    int wc = write_count;
    run_frame(3, 1'b1);
    vectors = vectors + 1;
    if (write_count - wc !== N) begin
      miscompares = miscompares + 1;
      $display("FAIL gap_writes: got %0d writes want %0d", write_count - wc, N);
    end
  endtask

  task automatic test_done_ignored();
    start_frame();
    for (int i = 0; i < 3; i++) send_sample(SW'(-100 * i), 0);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    vectors = vectors + 1;
    if (frame_count !== fc_exp || busy !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL done_in_fill: got count=%0d busy=%b want count=%0d busy=1", frame_count, busy, fc_exp);
    end
    for (int i = 3; i < N * SPW; i++) send_sample(SW'(-100 * i), 0);
    wait_start();
    finish_frame();
  endtask

  task automatic test_back_to_back();
    arm   = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    exp_addr   = 3'd0;
    pair_phase = 1'b0;
    for (int i = 0; i < N * SPW; i++) send_sample(SW'(1000 + i), 0);
    wait_start();
    done = 1'b1;
    @(posedge clk); #1;
    done   = 1'b0;
    fc_exp = fc_exp + 8'd1;
    vectors = vectors + 1;
    if (frame_count !== fc_exp || busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_end: got count=%0d busy=%b want count=%0d busy=0", frame_count, busy, fc_exp);
    end
    @(posedge clk); #1;
    arm = 1'b0;
    vectors = vectors + 1;
    if (busy !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL b2b_rearm: got busy=%b want 1", busy);
    end
    exp_addr   = 3'd0;
    pair_phase = 1'b0;
    for (int i = 0; i < N * SPW; i++) send_sample(SW'(-1000 - i), 0);
    wait_start();
    finish_frame();
  endtask

  task automatic test_idle_inputs();
    int wc = write_count;
    sample_valid = 1'b1;
    sample_in    = 16'sh7FFF;
    done         = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    sample_valid = 1'b0;
    done         = 1'b0;
    @(posedge clk); #1;
    vectors = vectors + 1;
    if (write_count !== wc || busy !== 1'b0 || frame_count !== fc_exp) begin
      miscompares = miscompares + 1;
      $display("FAIL idle_inputs: got writes=%0d busy=%b count=%0d want writes=%0d busy=0 count=%0d",
               write_count - wc, busy, frame_count, 0, fc_exp);
    end
  endtask

`ifdef LOADER_DECIM_EN
  task automatic test_decim();
    start_frame();
    send_sample(-16'sd4, 0);
    send_sample(16'sd2, 0);
    send_sample(16'sd7, 0);
    send_sample(16'sd8, 0);
    for (int i = 4; i < N * SPW; i++) send_sample(SW'($urandom_range(0, 65535)), 0);
    wait_start();
    finish_frame();
  endtask
`endif

  task automatic test_wrap();
    int guard = 0;
    while (fc_exp != 8'd255 && guard < 300) begin
      run_frame(0, 1'b1);
      guard++;
    end
    vectors = vectors + 1;
    if (frame_count !== 8'd255) begin
      miscompares = miscompares + 1;
      $display("FAIL count_255: got %0d want 255", frame_count);
    end
    run_frame(0, 1'b1);
    vectors = vectors + 1;
    if (frame_count !== 8'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL count_wrap: got %0d want 0", frame_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    int sc;
    start_frame();
    for (int i = 0; i < 5 * SPW; i++) send_sample(SW'(77 + i), 0);
    #6;
    rst_n = 1'b0;
    #1;
    vectors = vectors + 1;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_fill: got en=%b busy=%b want 0 0", wr_en, busy);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    fc_exp = 8'd0;
    sc = start_count;
    repeat (10) begin @(posedge clk); #1; end
    vectors = vectors + 1;
    if (start_count !== sc || busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL no_start_after_reset: got starts=%0d busy=%b want starts=%0d busy=0", start_count, busy, sc);
    end
    run_frame(0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_gaps();
    test_done_ignored();
    test_back_to_back();
    test_idle_inputs();
`ifdef LOADER_DECIM_EN
    test_decim();
`endif
    test_wrap();
    test_reset_mid_fill();
    repeat (3) begin @(posedge clk); #1; end
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL pending_writes: got %0d outstanding want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
